// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, 16x32 register file, decoder, condition check, hazard stall and ID/EX register.
// Define ID_FORWARDING_EN when a downstream forwarding unit exists; only load-use hazards then stall.
module id_stage #(
    parameter int REG_COUNT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        flush,
    input  logic [3:0]  status,
    input  logic [3:0]  hz_exe_dest,
    input  logic        hz_exe_wb_en,
    input  logic        hz_exe_mem_r_en,
    input  logic [3:0]  hz_mem_dest,
    input  logic        hz_mem_wb_en,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic        freeze,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [3:0]  ex_exe_cmd,
    output logic        ex_mem_r_en,
    output logic        ex_mem_w_en,
    output logic        ex_wb_en,
    output logic        ex_b,
    output logic        ex_s,
    output logic [31:0] ex_val_rn,
    output logic [31:0] ex_val_rm,
    output logic        ex_imm,
    output logic [11:0] ex_shift_operand,
    output logic [23:0] ex_signed_imm_24,
    output logic [3:0]  ex_dest,
    output logic [3:0]  ex_src1,
    output logic [3:0]  ex_src2
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        b;
        logic        s;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } idex_t;

    logic [31:0] if_pc_q;
    logic [31:0] instr_q;
    logic        id_valid_q;
    logic [31:0] regs_q [REG_COUNT];
    idex_t       ex_q;
    idex_t       ex_d;

    logic [3:0]  cond_s;
    logic [1:0]  mode_s;
    logic [3:0]  opcode_s;
    logic        s_bit_s;
    logic [3:0]  rn_s;
    logic [3:0]  rd_s;
    logic [3:0]  src2_s;
    logic [31:0] val_rn_s;
    logic [31:0] val_rm_s;
    logic        dec_valid_s;
    logic [3:0]  cmd_s;
    logic        mem_r_s;
    logic        mem_w_s;
    logic        wb_s;
    logic        b_s;
    logic        s_s;
    logic        use_rn_s;
    logic        use_src2_s;
    logic        exe_hit_s;
    logic        mem_hit_s;
    logic        hazard_s;
    logic        issue_s;
    logic        unused_s;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = !z;
            4'b0010: pass = c;
            4'b0011: pass = !c;
            4'b0100: pass = n;
            4'b0101: pass = !n;
            4'b0110: pass = v;
            4'b0111: pass = !v;
            4'b1000: pass = c & !z;
            4'b1001: pass = !c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = !z & (n == v);
            4'b1101: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
        return pass;
    endfunction

    assign cond_s   = instr_q[31:28];
    assign mode_s   = instr_q[27:26];
    assign opcode_s = instr_q[24:21];
    assign s_bit_s  = instr_q[20];
    assign rn_s     = instr_q[19:16];
    assign rd_s     = instr_q[15:12];
    assign src2_s   = (mode_s == 2'b01 && !s_bit_s) ? rd_s : instr_q[3:0];

    // IF/ID latch: flush squashes, freeze holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc_q    <= 32'h0;
            instr_q    <= 32'h0;
            id_valid_q <= 1'b0;
        end else if (flush) begin
            id_valid_q <= 1'b0;
        end else if (!freeze) begin
            if_pc_q    <= if_pc;
            instr_q    <= if_instruction;
            id_valid_q <= 1'b1;
        end
    end

    // Register file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 32'h0;
        end else if (wb_en) begin
            regs_q[wb_dest] <= wb_value;
        end
    end

    // Same-cycle write-back is bypassed so no stall is needed for it
    assign val_rn_s = (wb_en && wb_dest == rn_s)   ? wb_value : regs_q[rn_s];
    assign val_rm_s = (wb_en && wb_dest == src2_s) ? wb_value : regs_q[src2_s];

    // Instruction decoder and source-usage flags
    always_comb begin
        dec_valid_s = 1'b0;
        cmd_s       = 4'b0000;
        mem_r_s     = 1'b0;
        mem_w_s     = 1'b0;
        wb_s        = 1'b0;
        b_s         = 1'b0;
        s_s         = 1'b0;
        use_rn_s    = 1'b0;
        use_src2_s  = 1'b0;
        case (mode_s)
            2'b00: begin
                dec_valid_s = 1'b1;
                wb_s        = 1'b1;
                s_s         = s_bit_s;
                use_rn_s    = 1'b1;
                use_src2_s  = !instr_q[25];
                case (opcode_s)
                    4'b1101: begin cmd_s = 4'b0001; use_rn_s = 1'b0; end
                    4'b1111: begin cmd_s = 4'b1001; use_rn_s = 1'b0; end
                    4'b0100: cmd_s = 4'b0010;
                    4'b0101: cmd_s = 4'b0011;
                    4'b0010: cmd_s = 4'b0100;
                    4'b0110: cmd_s = 4'b0101;
                    4'b0000: cmd_s = 4'b0110;
                    4'b1100: cmd_s = 4'b0111;
                    4'b0001: cmd_s = 4'b1000;
                    4'b1010: begin cmd_s = 4'b0100; wb_s = 1'b0; end
                    4'b1000: begin cmd_s = 4'b0110; wb_s = 1'b0; end
                    default: begin dec_valid_s = 1'b0; wb_s = 1'b0; s_s = 1'b0; end
                endcase
            end
            2'b01: begin
                dec_valid_s = 1'b1;
                cmd_s       = 4'b0010;
                use_rn_s    = 1'b1;
                if (s_bit_s) begin
                    mem_r_s = 1'b1;
                    wb_s    = 1'b1;
                end else begin
                    mem_w_s    = 1'b1;
                    use_src2_s = 1'b1;
                end
            end
            2'b10: begin
                dec_valid_s = 1'b1;
                b_s         = 1'b1;
            end
            default: dec_valid_s = 1'b0;
        endcase
    end

    assign exe_hit_s = (use_rn_s && rn_s == hz_exe_dest) || (use_src2_s && src2_s == hz_exe_dest);
    assign mem_hit_s = (use_rn_s && rn_s == hz_mem_dest) || (use_src2_s && src2_s == hz_mem_dest);

`ifdef ID_FORWARDING_EN
    assign hazard_s = hz_exe_mem_r_en & hz_exe_wb_en & exe_hit_s;
    assign unused_s = ^{hz_mem_dest, hz_mem_wb_en, mem_hit_s};
`else
    assign hazard_s = (hz_exe_wb_en & exe_hit_s) | (hz_mem_wb_en & mem_hit_s);
    assign unused_s = hz_exe_mem_r_en;
`endif

    assign freeze  = id_valid_q & ~flush & hazard_s;
    assign issue_s = id_valid_q & dec_valid_s & cond_pass(cond_s, status) & ~freeze & ~flush;

    // ID/EX next state: a real instruction or an all-zero bubble
    always_comb begin
        ex_d = '0;
        if (issue_s) begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = if_pc_q;
            ex_d.cmd      = cmd_s;
            ex_d.mem_r_en = mem_r_s;
            ex_d.mem_w_en = mem_w_s;
            ex_d.wb_en    = wb_s;
            ex_d.b        = b_s;
            ex_d.s        = s_s;
            ex_d.val_rn   = val_rn_s;
            ex_d.val_rm   = val_rm_s;
            ex_d.imm      = instr_q[25];
            ex_d.shift    = instr_q[11:0];
            ex_d.simm     = instr_q[23:0];
            ex_d.dest     = rd_s;
            ex_d.src1     = rn_s;
            ex_d.src2     = src2_s;
        end else begin
            ex_d = '0;
        end
    end

    // ID/EX register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid         = ex_q.valid;
    assign ex_pc            = ex_q.pc;
    assign ex_exe_cmd       = ex_q.cmd;
    assign ex_mem_r_en      = ex_q.mem_r_en;
    assign ex_mem_w_en      = ex_q.mem_w_en;
    assign ex_wb_en         = ex_q.wb_en;
    assign ex_b             = ex_q.b;
    assign ex_s             = ex_q.s;
    assign ex_val_rn        = ex_q.val_rn;
    assign ex_val_rm        = ex_q.val_rm;
    assign ex_imm           = ex_q.imm;
    assign ex_shift_operand = ex_q.shift;
    assign ex_signed_imm_24 = ex_q.simm;
    assign ex_dest          = ex_q.dest;
    assign ex_src1          = ex_q.src1;
    assign ex_src2          = ex_q.src2;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage ARM-subset pipeline. It sits directly after instruction fetch and consumes the fetch stage's PC and instruction word. The block contains the IF/ID latch, the 16×32 register file, the instruction decoder, condition-code evaluation and hazard detection. It drives `freeze` back to fetch and produces a registered ID/EX bundle for the execute stage.

## Interface
Parameters:
- `REG_COUNT`, 16: architectural registers; must be 16.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `if_pc` in 32: address of the fetched instruction.
- `if_instruction` in 32: fetched instruction word.
- `flush` in 1: branch taken in EXE; squash the younger instructions.
- `status` in 4: {N,Z,C,V} from the status register.
- `hz_exe_dest` in 4, `hz_exe_wb_en` in 1, `hz_exe_mem_r_en` in 1: destination of the EXE-stage instruction.
- `hz_mem_dest` in 4, `hz_mem_wb_en` in 1: destination of the MEM-stage instruction.
- `wb_en` in 1, `wb_dest` in 4, `wb_value` in 32: register-file write port.
- `freeze` out 1: stall request to fetch (combinational).
- `ex_valid` out 1: the ID/EX slot holds a real instruction.
- `ex_pc` out 32: PC of the instruction.
- `ex_exe_cmd` out 4: ALU command.
- `ex_mem_r_en`, `ex_mem_w_en`, `ex_wb_en`, `ex_b`, `ex_s` out 1 each: control bits.
- `ex_val_rn` out 32, `ex_val_rm` out 32: operand values.
- `ex_imm` out 1: immediate operand (instruction bit 25).
- `ex_shift_operand` out 12: instruction bits [11:0].
- `ex_signed_imm_24` out 24: instruction bits [23:0].
- `ex_dest` out 4, `ex_src1` out 4, `ex_src2` out 4: register numbers.

## Operation
- **IF/ID latch.** Captures `{if_pc, if_instruction}` and sets `id_valid` = 1 on each clock.
  - `flush` clears `id_valid`.
  - Otherwise, `freeze` holds the latch contents.
- **Decode fields.** cond = [31:28], mode = [27:26], I = [25], opcode = [24:21], S = [20], Rn = [19:16], Rd = [15:12], Rm = [3:0].
- **Mode 00, opcode → exe_cmd:**
  - MOV 1101→0001; MVN 1111→1001.
  - ADD 0100→0010; ADC 0101→0011.
  - SUB 0010→0100; SBC 0110→0101.
  - AND 0000→0110; ORR 1100→0111; EOR 0001→1000.
  - CMP 1010→0100 (wb_en = 0); TST 1000→0110 (wb_en = 0).
  - All others: wb_en = 1.
  - Unlisted opcodes decode as a bubble.
- **Mode 01 (memory):** exe_cmd = 0010.
  - S = 1 is LDR: mem_r_en = 1, wb_en = 1.
  - S = 0 is STR: mem_w_en = 1, wb_en = 0.
- **Mode 10:** b = 1, all other controls 0.
- **Sources:**
  - src1 = Rn.
  - src2 = Rd for STR, else Rm.
- **Source usage:**
  - Rn is used except by MOV, MVN and B.
  - src2 is used for STR, and for mode 00 with I = 0.
- **Condition check.**
  - Codes: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - 1110 and 1111 always pass.
  - A failing condition issues a bubble.
- **Bubble.** `ex_valid`, `mem_r_en`, `mem_w_en`, `wb_en`, `b` and `s` are all 0. Data fields are don't-care.
- **Hazard detection (no forwarding):** `freeze` = id_valid & !flush & (a used source matches (hz_exe_wb_en & hz_exe_dest) or (hz_mem_wb_en & hz_mem_dest)). While frozen, ID/EX receives a bubble.
- **Register file.**
  - 16×32, all registers reset to 0.
  - Written on the clock edge when `wb_en`.
  - Reads are combinational, with bypass: a read of `wb_dest` while `wb_en` returns `wb_value`.
- **Priority:** rst > flush > freeze > normal.
- **Flush.** Clears `id_valid` and loads a bubble into ID/EX on the same edge.

## Timing
- **Reset.** All ID/EX outputs are 0, `id_valid` = 0, all registers are 0. `freeze` = 0, because `id_valid` = 0.
- **Latency.** An instruction presented at edge N is in IF/ID after N. Its ID/EX outputs are valid after edge N+1 (one stage).
- **Flush.** `flush` high at edge N squashes the instructions in both IF/ID and ID/EX. At N+1, IF/ID captures the fetch of the branch target.
- **Freeze.** `freeze` and `flush` high together: flush wins and `freeze` is forced to 0.
- **Reset mid-stall.** Everything clears immediately; no state survives.
- **Write-back collision.** A same-cycle write-back to a source register is visible via the bypass. No extra stall.

## Configuration
- **`ID_FORWARDING_EN` defined:** a forwarding unit exists downstream.
  - `freeze` = id_valid & !flush & hz_exe_mem_r_en & hz_exe_wb_en & (used source == hz_exe_dest). Load-use only.
  - MEM-stage matches are ignored.
- **Undefined:** the full EXE/MEM comparison above applies.

## Test plan
- **Reset then MOV R0,#20 (0xE3A00014):** after 2 edges, ex_valid = 1, ex_exe_cmd = 0001, ex_wb_en = 1, ex_dest = 0, ex_imm = 1, ex_shift_operand = 0x014.
- **Register-file bypass:** write R2 = 0xC0000000 via wb_en; ADDS R3,R2,R2 gives ex_val_rn = ex_val_rm = 0xC0000000, ex_s = 1, ex_exe_cmd = 0010. The same holds with wb in the same cycle as the read.
- **Condition codes:** ADDNE with status Z = 1 gives a bubble (ex_valid = 0, ex_wb_en = 0). With Z = 0 it issues. BLT with N = 1, V = 0 gives ex_b = 1 and ex_signed_imm_24 = 0xFFFFF7.
- **RAW hazard (no macro):** hz_exe_dest = 3, hz_exe_wb_en = 1, with ADD R4,R0,R3,LSL #2 in ID: freeze = 1 and a bubble issues. Clearing the hazard releases the instruction the next edge with the same ex_pc. With `ID_FORWARDING_EN` and hz_exe_mem_r_en = 0, freeze = 0.
- **Flush:** flush = 1 with a valid instruction in IF/ID: ex_valid = 0 next edge. The subsequent ex_valid = 0 shows the squashed instruction never issues.
- **Async reset mid-freeze:** rst pulsed between edges clears all outputs and drops freeze to 0 immediately.
